// File: rtl/lsu_bus_pkg.sv
// Shared types and helpers for the LSU data-bus initiator.
// Lane mask and alignment rules live here so the FSM and the aligner agree on them.
package lsu_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR      = 2'd2,
        ST_RESP    = 2'd3
    } lsu_state_e;

    function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] a);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << a;
            SZ_HALF: m = 4'b0011 << a;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Size 3 has no legal alignment, so it always reports misaligned.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] a);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = a[0];
            SZ_WORD: bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store mask/replication and load shift/extension.
module lsu_lane_align
    import lsu_bus_pkg::*;
(
    input  size_e       i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_mask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;
    logic        w_sign;

    always_comb begin
        o_mask = lane_mask(i_size, i_addr_lo);
        case (i_size)
            SZ_BYTE: o_wdata = {4{i_wdata[7:0]}};
            SZ_HALF: o_wdata = {2{i_wdata[15:0]}};
            default: o_wdata = i_wdata;
        endcase
    end

    always_comb begin
        w_shifted = i_rdata >> {i_addr_lo, 3'b000};
        w_sign    = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                w_sign  = ~i_unsigned & w_shifted[7];
                o_rdata = {{24{w_sign}}, w_shifted[7:0]};
            end
            SZ_HALF: begin
                w_sign  = ~i_unsigned & w_shifted[15];
                o_rdata = {{16{w_sign}}, w_shifted[15:0]};
            end
            default: o_rdata = w_shifted;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Single-outstanding load/store initiator for the data-memory bus.
// Define LSU_BUS_TIMEOUT_EN to abort read waits after TIMEOUT_CYCLES.
module lsu_bus_master
    import lsu_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_rd_wr_en,
    output logic        bus_cs,
    output logic [3:0]  bus_mask,
    input  logic [31:0] bus_rdata,
    input  logic        bus_valid
);

    lsu_state_e  r_state;
    size_e       r_size;
    logic        r_unsigned;
    logic [1:0]  r_addr_lo;

    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic        r_bus_rd_wr_en;
    logic        r_bus_cs;
    logic [3:0]  r_bus_mask;

    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic        w_idle;
    logic        w_accept;
    logic        w_misalign;
    size_e       w_req_size;
    size_e       w_al_size;
    logic [1:0]  w_al_addr_lo;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            w_expired;
    assign w_expired = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = req_valid & w_idle;
    assign w_req_size = size_e'(req_size);
    assign w_misalign = is_misaligned(w_req_size, req_addr[1:0]);

    // One aligner serves both directions: live request while idle, captured request while reading.
    assign w_al_size    = w_idle ? w_req_size : r_size;
    assign w_al_addr_lo = w_idle ? req_addr[1:0] : r_addr_lo;

    lsu_lane_align u_align (
        .i_size     (w_al_size),
        .i_addr_lo  (w_al_addr_lo),
        .i_unsigned (r_unsigned),
        .i_wdata    (req_wdata),
        .i_rdata    (bus_rdata),
        .o_mask     (w_mask),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_size         <= SZ_BYTE;
            r_unsigned     <= 1'b0;
            r_addr_lo      <= 2'b00;
            r_bus_addr     <= '0;
            r_bus_wdata    <= '0;
            r_bus_rd_wr_en <= 1'b1;
            r_bus_cs       <= 1'b1;
            r_bus_mask     <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_err      <= 1'b0;
            r_rsp_rdata    <= '0;
`ifdef LSU_BUS_TIMEOUT_EN
            r_to_cnt       <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_size     <= w_req_size;
                        r_unsigned <= req_unsigned;
                        r_addr_lo  <= req_addr[1:0];
                        if (w_misalign) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_bus_cs       <= 1'b0;
                            r_bus_addr     <= {req_addr[31:2], 2'b00};
                            r_bus_mask     <= w_mask;
                            r_bus_wdata    <= w_wdata;
                            r_bus_rd_wr_en <= ~req_we;
                            r_state        <= req_we ? ST_WR : ST_RD_WAIT;
`ifdef LSU_BUS_TIMEOUT_EN
                            r_to_cnt       <= '0;
`endif
                        end
                    end
                end
                ST_RD_WAIT: begin
                    // Valid data on the expiry cycle still completes normally.
                    if (bus_valid) begin
                        r_bus_cs    <= 1'b1;
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= w_rdata;
                    end
`ifdef LSU_BUS_TIMEOUT_EN
                    else if (w_expired) begin
                        r_bus_cs    <= 1'b1;
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                ST_WR: begin
                    r_bus_cs    <= 1'b1;
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready    = w_idle;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_err      = r_rsp_err;
    assign rsp_rdata    = r_rsp_rdata;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;
    assign bus_rd_wr_en = r_bus_rd_wr_en;
    assign bus_cs       = r_bus_cs;
    assign bus_mask     = r_bus_mask;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master with a behavioural memory and a transaction-level model.
// Timeout cases are exercised only when LSU_BUS_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_lsu_bus_master;

    localparam int TO    = 16;
    localparam int NEVER = 100000;
`ifdef LSU_BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rd_wr_en;
    logic        bus_cs;
    logic [3:0]  bus_mask;
    logic [31:0] bus_rdata = '0;
    logic        bus_valid;

    lsu_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rd_wr_en(bus_rd_wr_en),
        .bus_cs(bus_cs), .bus_mask(bus_mask),
        .bus_rdata(bus_rdata), .bus_valid(bus_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%08h, required 0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d): wait bound expired, event never seen", name, cyc);
    endtask

    // Memory: answers a read after mem_delay edges of chip-select, commits writes on the edge.
    logic [31:0] mem [0:63];
    int          mem_delay = 1;
    int          mem_cnt   = 0;
    logic        mem_valid = 1'b0;
    logic        spurious  = 1'b0;
    int          cs_lows   = 0;

    assign bus_valid = mem_valid | spurious;

    always @(posedge clk) begin
        if (!bus_cs && bus_rd_wr_en) begin
            bus_rdata <= mem[bus_addr[7:2]];
            mem_valid <= (mem_cnt + 1 >= mem_delay);
            mem_cnt   <= mem_cnt + 1;
        end else begin
            mem_valid <= 1'b0;
            mem_cnt   <= 0;
        end
        if (!bus_cs && !bus_rd_wr_en)
            for (int i = 0; i < 4; i++)
                if (bus_mask[i]) mem[bus_addr[7:2]][8*i +: 8] <= bus_wdata[8*i +: 8];
    end

    always @(negedge clk) if (!bus_cs) cs_lows++;

    // Transaction model: cycle windows for chip-select and response, plus expected bus/response values.
    bit          m_busy = 1'b0;
    bit          m_is_load = 1'b0;
    int          m_start = -1, m_end = -1, m_rsp = -1, k_m;
    logic [1:0]  m_sz, m_a;
    logic        m_uns;
    logic [31:0] p_rdata = '0, v_rdata = '0;
    logic        p_err = 1'b0, v_err = 1'b0;
    logic [31:0] v_addr = '0, v_wdata = '0;
    logic [3:0]  v_mask = '0;
    logic        v_rd = 1'b1;

    function automatic bit bad_align(input logic [1:0] sz, input logic [1:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a != 2'd0);
    endfunction

    function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] a, input logic uns);
        logic [31:0] v;
        v = w >> (8 * a);
        if (sz == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_start = -1; m_end = -1; m_rsp = -1;
            v_rdata = '0; v_err = 1'b0; v_addr = '0; v_wdata = '0; v_mask = '0; v_rd = 1'b1;
        end else begin
            k_m = cyc;
            if (!m_busy && req_valid) begin
                m_busy = 1'b1; m_sz = req_size; m_uns = req_unsigned; m_a = req_addr[1:0];
                m_is_load = !req_we; p_rdata = '0;
                if (bad_align(req_size, req_addr[1:0])) begin
                    m_start = -1; m_end = -1; m_rsp = k_m + 1; p_err = 1'b1;
                end else begin
                    m_start = k_m + 1; p_err = 1'b0;
                    v_addr  = req_addr & 32'hFFFF_FFFC;
                    v_rd    = !req_we;
                    v_mask  = (req_size == 2'd0) ? (4'b0001 << req_addr[1:0]) :
                              (req_size == 2'd1) ? (4'b0011 << req_addr[1:0]) : 4'b1111;
                    v_wdata = (req_size == 2'd0) ? (req_wdata & 32'hFF) * 32'h0101_0101 :
                              (req_size == 2'd1) ? (req_wdata & 32'hFFFF) * 32'h0001_0001 : req_wdata;
                    if (req_we) begin m_end = k_m + 1; m_rsp = k_m + 2; end
                    else        begin m_end = -1;      m_rsp = -1;      end
                end
            end else if (m_busy && m_is_load && m_start >= 0 && m_end < 0 && k_m >= m_start) begin
                if (bus_valid) begin
                    m_end = k_m; m_rsp = k_m + 1; p_rdata = ext_load(bus_rdata, m_sz, m_a, m_uns);
                end else if (TO_EN && k_m == m_start + TO - 1) begin
                    m_end = k_m; m_rsp = k_m + 1; p_err = 1'b1; p_rdata = '0;
                end
            end else if (m_busy && k_m == m_rsp) begin
                m_busy = 1'b0;
            end
            cyc = k_m + 1;
            if (cyc == m_rsp) begin v_rdata = p_rdata; v_err = p_err; end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("bus_cs", 32'(bus_cs),
                32'(!(m_start >= 0 && cyc >= m_start && (m_end < 0 || cyc <= m_end))));
            chk("bus_rd_wr_en", 32'(bus_rd_wr_en), 32'(v_rd));
            chk("bus_addr", bus_addr, v_addr);
            chk("bus_mask", 32'(bus_mask), 32'(v_mask));
            chk("bus_wdata", bus_wdata, v_wdata);
            chk("rsp_valid", 32'(rsp_valid), 32'(cyc == m_rsp));
            chk("rsp_err", 32'(rsp_err), 32'(v_err));
            chk("rsp_rdata", rsp_rdata, v_rdata);
            chk("req_ready", 32'(req_ready), 32'(!m_busy));
        end
    end

    // One access: lat counts cycles from the accept cycle to the rsp_valid cycle,
    // so a load answered on the first edge gives 3 (4 cycles inclusive), a store 2.
    task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic [31:0] b_addr, output logic [3:0] b_mask,
                          output logic [31:0] b_wdata, output int lows);
        int n;
        int low0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 64) begin @(posedge clk); #1; n++; end
        if (!req_ready) bound_fail("accept_wait");
        low0 = cs_lows;
        @(posedge clk); #1;
        req_valid = 1'b0;
        b_addr = bus_addr; b_mask = bus_mask; b_wdata = bus_wdata;
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!rsp_valid) bound_fail("rsp_wait");
        rd = rsp_rdata; er = rsp_err;
        chk("no_ready_in_rsp", 32'(req_ready), 32'd0);
        lows = cs_lows - low0;
    endtask

    typedef struct {
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] exp;
        string       name;
    } ld_t;

    logic [31:0] rd, ba, bw;
    logic [3:0]  bm;
    logic        er;
    int          lat, lows;
    ld_t         lds[4];
    ld_t         mis[3];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[4] = 32'h1122_3344;
        mem[8] = 32'h80F1_7FFE;
        mem[9] = 32'hCAFE_F00D;

        repeat (2) @(posedge clk); #1;
        chk("rst_bus_cs", 32'(bus_cs), 32'd1);
        chk("rst_rd_wr_en", 32'(bus_rd_wr_en), 32'd1);
        chk("rst_mask", 32'(bus_mask), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        access(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00A5, rd, er, lat, ba, bm, bw, lows);
        chk("sb_addr", ba, 32'h10);
        chk("sb_mask", 32'(bm), 32'h8);
        chk("sb_wdata", bw, 32'hA5A5_A5A5);
        chk("sb_cs_cycles", 32'(lows), 32'd1);
        chk("sb_latency", 32'(lat), 32'd2);
        chk("sb_err", 32'(er), 32'd0);
        chk("sb_rdata", rd, 32'd0);

        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, ba, bm, bw, lows);
        chk("lw_top_byte", 32'(rd[31:24]), 32'hA5);
        chk("lw_word", rd, 32'hA522_3344);
        chk("lw_latency", 32'(lat), 32'd3);
        chk("lw_cs_cycles", 32'(lows), 32'd2);

        lds[0] = '{2'd0, 1'b1, 32'h20, 32'h0000_00FE, "lbu_20"};
        lds[1] = '{2'd0, 1'b0, 32'h23, 32'hFFFF_FF80, "lb_23"};
        lds[2] = '{2'd1, 1'b0, 32'h22, 32'hFFFF_80F1, "lh_22"};
        lds[3] = '{2'd1, 1'b1, 32'h20, 32'h0000_7FFE, "lhu_20"};
        foreach (lds[i]) begin
            access(1'b0, lds[i].sz, lds[i].uns, lds[i].a, 32'h0, rd, er, lat, ba, bm, bw, lows);
            chk(lds[i].name, rd, lds[i].exp);
            chk({lds[i].name, "_err"}, 32'(er), 32'd0);
        end

        mis[0] = '{2'd2, 1'b0, 32'h06, 32'h0, "mis_lw_06"};
        mis[1] = '{2'd1, 1'b0, 32'h01, 32'h0, "mis_sh_01"};
        mis[2] = '{2'd3, 1'b0, 32'h00, 32'h0, "mis_size3"};
        foreach (mis[i]) begin
            access(i == 1, mis[i].sz, 1'b0, mis[i].a, 32'hFFFF_FFFF, rd, er, lat, ba, bm, bw, lows);
            chk({mis[i].name, "_err"}, 32'(er), 32'd1);
            chk({mis[i].name, "_lat"}, 32'(lat), 32'd1);
            chk({mis[i].name, "_cs"}, 32'(lows), 32'd0);
            chk({mis[i].name, "_rdata"}, rd, 32'd0);
        end

        mem_delay = 5;
        access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, ba, bm, bw, lows);
        chk("slow_lw_data", rd, 32'h80F1_7FFE);
        chk("slow_lw_lat", 32'(lat), 32'd7);
        chk("slow_lw_cs", 32'(lows), 32'd6);
        mem_delay = 1;

        spurious = 1'b1;
        access(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_1234, rd, er, lat, ba, bm, bw, lows);
        chk("sh_mask", 32'(bm), 32'hC);
        chk("sh_wdata", bw, 32'h1234_1234);
        chk("sh_latency", 32'(lat), 32'd2);
        @(posedge clk); #1;
        spurious = 1'b0;
        access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, ba, bm, bw, lows);
        chk("lw_after_sh", rd, 32'h1234_7FFE);

`ifdef LSU_BUS_TIMEOUT_EN
        mem_delay = NEVER;
        access(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, rd, er, lat, ba, bm, bw, lows);
        chk("to_err", 32'(er), 32'd1);
        chk("to_rdata", rd, 32'd0);
        chk("to_lat", 32'(lat), 32'd17);
        chk("to_cs_cycles", 32'(lows), 32'd16);
        chk("to_cs_released", 32'(bus_cs), 32'd1);
        mem_delay = TO - 1;
        access(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, rd, er, lat, ba, bm, bw, lows);
        chk("to_edge_err", 32'(er), 32'd0);
        chk("to_edge_data", rd, 32'hCAFE_F00D);
        chk("to_edge_lat", 32'(lat), 32'd17);
`else
        mem_delay = 20;
        access(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, rd, er, lat, ba, bm, bw, lows);
        chk("long_wait_err", 32'(er), 32'd0);
        chk("long_wait_data", rd, 32'hCAFE_F00D);
        chk("long_wait_lat", 32'(lat), 32'd22);
`endif

        mem_delay = NEVER;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h24;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("rd_wait_cs_low", 32'(bus_cs), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs", 32'(bus_cs), 32'd1);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_delay = 1;
        access(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, rd, er, lat, ba, bm, bw, lows);
        chk("post_rst_lbu", rd, 32'h0000_00FE);
        chk("post_rst_lat", 32'(lat), 32'd3);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
